// File: rtl/svpwm_duty.sv
// Space-vector PWM duty generator: alpha/beta voltages in, three clamped compare values out.
// Five-state sequential datapath (IDLE, MUL, PHASE, INJECT, OUT), one conversion per 5 clocks.
module svpwm_duty #(
    parameter int D_WIDTH    = 32,
    parameter int Q_BITS     = 10,
    parameter int DUTY_WIDTH = 16,
    parameter int PWM_MAX    = 1000
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic [D_WIDTH-1:0]    alpha,
    input  logic [D_WIDTH-1:0]    beta,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [DUTY_WIDTH-1:0] duty_a,
    output logic [DUTY_WIDTH-1:0] duty_b,
    output logic [DUTY_WIDTH-1:0] duty_c
);

    // Four guard bits keep every intermediate free of wrap-around for full-scale inputs.
    localparam int  W       = D_WIDTH + 4;
    localparam int  PW      = 2 * D_WIDTH;
    localparam real SQRT3_R = 1.7320508075688772;
    localparam logic signed [PW-1:0] SQRT3_Q = PW'($rtoi(SQRT3_R * (2.0 ** Q_BITS) + 0.5));
    localparam logic signed [W-1:0]  HALF    = W'(PWM_MAX >> 1);
    localparam logic signed [W-1:0]  PMAX    = W'(PWM_MAX);

    typedef enum logic [2:0] {IDLE, MUL, PHASE, INJECT, OUT} state_t;
    state_t state, state_nxt;

    logic signed [D_WIDTH-1:0] alpha_r, beta_r;
    logic signed [PW-1:0]      beta_x;
    logic signed [W-1:0]       alpha_w;
    logic signed [W-1:0]       term_r;
    logic signed [W-1:0]       va_r, vb_r, vc_r;
    logic signed [W-1:0]       vmax, vmin, voff;

    function automatic logic [DUTY_WIDTH-1:0] clampd(input logic signed [W-1:0] v);
        logic signed [W-1:0] s;
        s = HALF + v;
        if (s < 0)
            return '0;
        else if (s > PMAX)
            return DUTY_WIDTH'(PWM_MAX);
        else
            return DUTY_WIDTH'(s);
    endfunction

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = MUL;
            MUL:     state_nxt = PHASE;
            PHASE:   state_nxt = INJECT;
            INJECT:  state_nxt = OUT;
            OUT:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy    = (state != IDLE);
    assign beta_x  = PW'(beta_r);
    assign alpha_w = W'(alpha_r);

    // Common-mode offset: midpoint of the largest and smallest phase voltage.
    always_comb begin
        vmax = va_r;
        vmin = va_r;
        if (vb_r > vmax) vmax = vb_r;
        if (vc_r > vmax) vmax = vc_r;
        if (vb_r < vmin) vmin = vb_r;
        if (vc_r < vmin) vmin = vc_r;
        voff = (vmax + vmin) >>> 1;
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            alpha_r <= '0;
            beta_r  <= '0;
            term_r  <= '0;
            va_r    <= '0;
            vb_r    <= '0;
            vc_r    <= '0;
            duty_a  <= '0;
            duty_b  <= '0;
            duty_c  <= '0;
            done    <= 1'b0;
        end else begin
            done <= (state == OUT);
            case (state)
                IDLE: begin
                    if (start) begin
                        alpha_r <= $signed(alpha);
                        beta_r  <= $signed(beta);
                    end
                end
                MUL:    term_r <= W'((beta_x * SQRT3_Q) >>> Q_BITS);
                PHASE: begin
                    va_r <= alpha_w;
                    vb_r <= (term_r - alpha_w) >>> 1;
                    vc_r <= (-term_r - alpha_w) >>> 1;
                end
                INJECT: begin
                    va_r <= va_r - voff;
                    vb_r <= vb_r - voff;
                    vc_r <= vc_r - voff;
                end
                OUT: begin
                    duty_a <= clampd(va_r);
                    duty_b <= clampd(vb_r);
                    duty_c <= clampd(vc_r);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_svpwm_duty.sv
// Self-checking bench for svpwm_duty: directed vectors, handshake, reset and randomized
// conversions compared against an integer-arithmetic reference of the duty equations.
module tb_svpwm_duty;

    logic        clk = 1'b0;
    logic        rstb = 1'b1;
    logic [31:0] alpha = '0;
    logic [31:0] beta = '0;
    logic        start = 1'b0;
    logic        busy, done;
    logic [15:0] duty_a, duty_b, duty_c;

    int tests_run = 0;
    int fails = 0;
    int exp_a, exp_b, exp_c;

    svpwm_duty #(.D_WIDTH(32), .Q_BITS(10), .DUTY_WIDTH(16), .PWM_MAX(1000)) dut (
        .clk(clk), .rstb(rstb), .alpha(alpha), .beta(beta), .start(start),
        .busy(busy), .done(done), .duty_a(duty_a), .duty_b(duty_b), .duty_c(duty_c)
    );

    always #5 clk = ~clk;

    function automatic int sat(input longint v);
        longint s;
        s = 500 + v;
        if (s < 0) return 0;
        if (s > 1000) return 1000;
        return int'(s);
    endfunction

    function automatic void model(input longint a, input longint b,
                                  output int da, output int db, output int dc);
        longint term, v[3], mx, mn, voff;
        term = (b * 1774) >>> 10;
        v[0] = a;
        v[1] = (term - a) >>> 1;
        v[2] = (-a - term) >>> 1;
        mx = v[0];
        mn = v[0];
        for (int i = 1; i < 3; i++) begin
            if (v[i] > mx) mx = v[i];
            if (v[i] < mn) mn = v[i];
        end
        voff = (mx + mn) >>> 1;
        da = sat(v[0] - voff);
        db = sat(v[1] - voff);
        dc = sat(v[2] - voff);
    endfunction

    // Drives start immediately (caller keeps away from the rising edge); with hold_start a
    // competing start (alpha=200) is held high while busy and must be ignored.
    task automatic convert(input string name, input logic signed [31:0] a,
                           input logic signed [31:0] b, input bit hold_start);
        int lat, nb;
        model(a, b, exp_a, exp_b, exp_c);
        alpha = a;
        beta  = b;
        start = 1'b1;
        @(posedge clk); #1;
        start = hold_start;
        alpha = hold_start ? 32'd200 : $urandom;
        beta  = hold_start ? 32'd0 : $urandom;
        lat = 1;
        nb  = (busy === 1'b1) ? 1 : 0;
        while (done !== 1'b1 && lat < 12) begin
            @(posedge clk); #1;
            lat++;
            if (busy === 1'b1) nb++;
        end
        start = 1'b0;
        tests_run++;
        if (lat != 5) begin
            fails++;
            $display("FAIL %s latency: got %0d edges, expected 5", name, lat);
        end
        tests_run++;
        if (nb != 4 || busy !== 1'b0) begin
            fails++;
            $display("FAIL %s busy: got %0d busy cycles, busy=%b at done; expected 4 and 0",
                     name, nb, busy);
        end
        tests_run++;
        if (duty_a !== 16'(exp_a) || duty_b !== 16'(exp_b) || duty_c !== 16'(exp_c)) begin
            fails++;
            $display("FAIL %s duties: got %0d/%0d/%0d expected %0d/%0d/%0d (a=%0d b=%0d)",
                     name, duty_a, duty_b, duty_c, exp_a, exp_b, exp_c, a, b);
        end
    endtask

    task automatic test_reset();
        #1 rstb = 1'b0;
        #20;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || {duty_a, duty_b, duty_c} !== 48'd0) begin
            fails++;
            $display("FAIL reset_state: busy=%b done=%b duties=%0d/%0d/%0d expected 0/0/0/0/0",
                     busy, done, duty_a, duty_b, duty_c);
        end
        @(negedge clk);
        rstb = 1'b1;
        convert("zero_after_release", 0, 0, 1'b0);
    endtask

    task automatic test_vectors();
        @(negedge clk); convert("alpha_only", 200, 0, 1'b0);
        @(negedge clk); convert("beta_only", 0, 400, 1'b0);
        @(negedge clk); convert("sat_pos", 2000, 0, 1'b0);
        @(negedge clk); convert("sat_neg", -2000, 0, 1'b0);
        @(negedge clk); convert("beta_neg", -100, -300, 1'b0);
    endtask

    task automatic test_hold();
        int bad;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || duty_a !== 16'(exp_a) || duty_b !== 16'(exp_b) ||
                duty_c !== 16'(exp_c)) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            fails++;
            $display("FAIL hold: %0d cycles with done high or duties changed, expected 0", bad);
        end
    endtask

    task automatic test_ignore_busy();
        @(negedge clk);
        convert("busy_ignore", 0, 400, 1'b1);
        @(posedge clk); #1;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL busy_ignore_after: busy=%b done=%b expected 0/0", busy, done);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        convert("b2b_1", 200, 0, 1'b0);
        convert("b2b_2", 0, 400, 1'b0);
        convert("b2b_3", -350, 123, 1'b0);
    endtask

    task automatic test_reset_mid();
        int spurious;
        @(negedge clk);
        alpha = 32'd2000;
        beta  = 32'd0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rstb = 1'b0;
        #1;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || {duty_a, duty_b, duty_c} !== 48'd0) begin
            fails++;
            $display("FAIL reset_mid: busy=%b done=%b duties=%0d/%0d/%0d expected 0/0/0/0/0",
                     busy, done, duty_a, duty_b, duty_c);
        end
        @(negedge clk);
        rstb = 1'b1;
        spurious = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0 || {duty_a, duty_b, duty_c} !== 48'd0)
                spurious++;
        end
        tests_run++;
        if (spurious != 0) begin
            fails++;
            $display("FAIL reset_abort: %0d cycles with activity after release, expected 0",
                     spurious);
        end
        @(negedge clk);
        convert("after_reset", 200, 0, 1'b0);
    endtask

    task automatic test_random();
        logic signed [31:0] a, b;
        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0) begin
                a = $urandom;
                b = $urandom;
            end else begin
                a = int'($urandom_range(0, 3000)) - 1500;
                b = int'($urandom_range(0, 2000)) - 1000;
            end
            @(negedge clk);
            convert($sformatf("random_%0d", i), a, b, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_hold();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
